// File: rtl/ws2812b_chain_ctrl.sv
// ws2812b chain driver: fetches NUM_LEDS GRB words over a request/valid
// pixel interface and serialises them MSB-first onto dout with WS2812B
// bit timing, followed by a low latch period and a one-cycle done pulse.
//
// state | meaning
// IDLE  | line low, waiting for start (ignored in the done cycle)
// FETCH | first pixel requested, waiting for pix_valid
// HIGH  | dout high for T1H/T0H of the current bit
// LOW   | dout low for the rest of the bit period; pixel boundary handled here
// LATCH | dout low for LATCH_CYCLES, then done and back to IDLE
module ws2812b_chain_ctrl #(
  parameter int NUM_LEDS     = 8,
  parameter int T0H_CYCLES   = 40,
  parameter int T1H_CYCLES   = 80,
  parameter int BIT_CYCLES   = 125,
  parameter int LATCH_CYCLES = 6000,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk_100MHz,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  input  logic          pix_valid,
  input  logic [23:0]   pix_data,
  output logic          underrun,
  output logic          dout
);

  localparam int TMR_MAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TW-1:0] T1H_M1   = TW'(T1H_CYCLES - 1);
  localparam logic [TW-1:0] T0H_M1   = TW'(T0H_CYCLES - 1);
  localparam logic [TW-1:0] T1L_M1   = TW'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam logic [TW-1:0] T0L_M1   = TW'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam logic [TW-1:0] LATCH_M1 = TW'(LATCH_CYCLES - 1);
  localparam logic [AW-1:0] LAST_PIX = AW'(NUM_LEDS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pix_rd_q, pix_rd_d;
  logic [AW-1:0] pix_addr_q, pix_addr_d;
  logic [AW-1:0] pix_cnt_q, pix_cnt_d;
  logic          pend_q, pend_d;
  logic          underrun_q, underrun_d;
  logic          dout_q, dout_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [23:0]   hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d;

  logic          pix_accept;
  logic [23:0]   next_word;

  // Only a valid that answers the single outstanding request is taken.
  assign pix_accept = pend_q & pix_valid;
  // A word arriving exactly on the boundary cycle bypasses the holding register.
  assign next_word  = hold_vld_q ? hold_q : pix_data;

  function automatic logic [TW-1:0] high_m1(input logic b);
    return b ? T1H_M1 : T0H_M1;
  endfunction

  function automatic logic [TW-1:0] low_m1(input logic b);
    return b ? T1L_M1 : T0L_M1;
  endfunction

  // Next-state logic for the sequencer, bit timer and pixel fetch.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pix_rd_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_cnt_d  = pix_cnt_q;
    pend_d     = pend_q;
    underrun_d = underrun_q;
    dout_d     = dout_q;
    tmr_d      = tmr_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;

    if (((state_q == ST_HIGH) || (state_q == ST_LOW)) && pix_accept) begin
      hold_d     = pix_data;
      hold_vld_d = 1'b1;
      pend_d     = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        dout_d = 1'b0;
        if (start && !done_q) begin
          state_d    = ST_FETCH;
          busy_d     = 1'b1;
          pix_rd_d   = 1'b1;
          pix_addr_d = '0;
          pix_cnt_d  = '0;
          pend_d     = 1'b1;
          underrun_d = 1'b0;
          bit_cnt_d  = '0;
          hold_vld_d = 1'b0;
        end
      end

      ST_FETCH: begin
        if (pix_accept) begin
          shift_d   = pix_data;
          pend_d    = 1'b0;
          state_d   = ST_HIGH;
          dout_d    = 1'b1;
          bit_cnt_d = '0;
          tmr_d     = high_m1(pix_data[23]);
          if (pix_addr_q < LAST_PIX) begin
            pix_rd_d   = 1'b1;
            pix_addr_d = pix_addr_q + AW'(1);
            pend_d     = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (tmr_q == '0) begin
          state_d = ST_LOW;
          dout_d  = 1'b0;
          tmr_d   = low_m1(shift_q[23]);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end

      ST_LOW: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (bit_cnt_q != 5'd23) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          shift_d   = {shift_q[22:0], 1'b0};
          dout_d    = 1'b1;
          tmr_d     = high_m1(shift_q[22]);
          state_d   = ST_HIGH;
        end else if (pix_cnt_q == LAST_PIX) begin
          state_d = ST_LATCH;
          tmr_d   = LATCH_M1;
        end else if (hold_vld_q || pix_accept) begin
          shift_d    = next_word;
          hold_vld_d = 1'b0;
          pend_d     = 1'b0;
          pix_cnt_d  = pix_cnt_q + AW'(1);
          bit_cnt_d  = '0;
          dout_d     = 1'b1;
          tmr_d      = high_m1(next_word[23]);
          state_d    = ST_HIGH;
          if (pix_addr_q < LAST_PIX) begin
            pix_rd_d   = 1'b1;
            pix_addr_d = pix_addr_q + AW'(1);
            pend_d     = 1'b1;
          end
        end else begin
          // Late pixel: drop the rest of the frame; the stale request is
          // forgotten so its eventual valid has no effect.
          underrun_d = 1'b1;
          pend_d     = 1'b0;
          hold_vld_d = 1'b0;
          state_d    = ST_LATCH;
          tmr_d      = LATCH_M1;
        end
      end

      ST_LATCH: begin
        dout_d = 1'b0;
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        dout_d  = 1'b0;
        busy_d  = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any frame and forces the line low at once.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pix_rd_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_cnt_q  <= '0;
      pend_q     <= 1'b0;
      underrun_q <= 1'b0;
      dout_q     <= 1'b0;
      tmr_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pix_rd_q   <= pix_rd_d;
      pix_addr_q <= pix_addr_d;
      pix_cnt_q  <= pix_cnt_d;
      pend_q     <= pend_d;
      underrun_q <= underrun_d;
      dout_q     <= dout_d;
      tmr_q      <= tmr_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pix_rd   = pix_rd_q;
  assign pix_addr = pix_addr_q;
  assign underrun = underrun_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_ws2812b_chain_ctrl.sv
// Directed bench for ws2812b_chain_ctrl with shortened timing so several
// complete frames fit in a short run.
module tb_ws2812b_chain_ctrl;

  localparam int NL    = 2;
  localparam int T0H   = 3;
  localparam int T1H   = 7;
  localparam int BITC  = 12;
  localparam int LATCH = 40;
  // Cycle index (cycle 1 = first busy cycle) of done with 1-cycle pixel latency:
  // 2 fetch cycles + 48 bits + latch + 1.
  localparam int DUR_FULL = 2 + NL * 24 * BITC + LATCH + 1;
  // Underrun: pixel 0 only, then latch from the boundary.
  localparam int DUR_UNDR = 2 + 24 * BITC + LATCH + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pix_rd, underrun, dout;
  logic [0:0]  pix_addr;
  logic        src_valid, spur_valid;
  logic [23:0] src_data;
  logic [23:0] pix_mem [0:NL-1];
  int          lat1;

  int errors = 0;
  int checks = 0;

  int hi_len = 0;
  logic prev_dout = 1'b0;
  int hi_q[$];
  int addr_q[$];
  int rd_cnt = 0;

  always #5 clk = ~clk;

  ws2812b_chain_ctrl #(
    .NUM_LEDS(NL), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .BIT_CYCLES(BITC), .LATCH_CYCLES(LATCH)
  ) dut (
    .clk_100MHz(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_valid(src_valid | spur_valid),
    .pix_data(src_data), .underrun(underrun), .dout(dout)
  );

  // Line monitor: high-pulse widths and pixel read requests.
  always @(negedge clk) begin
    if (pix_rd === 1'b1) begin
      rd_cnt <= rd_cnt + 1;
      addr_q.push_back(int'(pix_addr));
    end
    if (dout === 1'b1) hi_len <= hi_len + 1;
    else if (prev_dout) begin
      hi_q.push_back(hi_len);
      hi_len <= 0;
    end
    prev_dout <= (dout === 1'b1);
  end

  // Pixel source: answers each pix_rd after 1 cycle (pixel 1 after lat1).
  initial begin
    int a, lat;
    src_valid = 1'b0;
    src_data  = '0;
    forever begin
      @(negedge clk);
      if (pix_rd === 1'b1) begin
        a   = int'(pix_addr);
        lat = (a == 1) ? lat1 : 1;
        repeat (lat) @(posedge clk);
        #1;
        src_valid = 1'b1;
        src_data  = pix_mem[a];
        @(posedge clk);
        #1 src_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic decode(input int base, output logic [23:0] w, output int bad);
    int v;
    w = '0;
    bad = 0;
    if (base + 24 > hi_q.size()) begin
      w = 'x;
      bad = 24;
    end else begin
      for (int i = 0; i < 24; i++) begin
        v = hi_q[base + i];
        w = {w[22:0], (v == T1H)};
        if (v != T1H && v != T0H) bad++;
      end
    end
  endtask

  task automatic run_frame(input string nm, input bit mid_start, input bit start_in_done,
                           input int exp_pulses, input logic [23:0] w0, input logic [23:0] w1,
                           input int exp_dur, input logic exp_und);
    int n, hb, rb, bad;
    logic [23:0] w;
    hb = hi_q.size();
    rb = rd_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({nm, "_busy1"}, busy, 1);
    chk({nm, "_rd1"}, pix_rd, 1);
    chk({nm, "_addr1"}, pix_addr, 0);
    chk({nm, "_und_clr"}, underrun, 0);
    n = 1;
    while (done !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (mid_start) start = (n == 100) || (n == 400);
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_dur"}, n, exp_dur);
    chk({nm, "_busy_done"}, busy, 0);
    chk({nm, "_underrun"}, underrun, exp_und);
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({nm, "_done_pulse"}, done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_rd_cnt"}, rd_cnt - rb, NL);
    chk({nm, "_addr0"}, addr_q[rb], 0);
    chk({nm, "_addr1_req"}, addr_q[rb + 1], 1);
    chk({nm, "_pulses"}, hi_q.size() - hb, exp_pulses);
    decode(hb, w, bad);
    chk({nm, "_pix0"}, w, w0);
    chk({nm, "_bad_hi0"}, bad, 0);
    if (exp_pulses == 48) begin
      decode(hb + 24, w, bad);
      chk({nm, "_pix1"}, w, w1);
      chk({nm, "_bad_hi1"}, bad, 0);
    end
  endtask

  initial begin
    int n, rb;
    rst = 1'b1;
    start = 1'b0;
    spur_valid = 1'b0;
    lat1 = 1;
    pix_mem[0] = 24'h000000;
    pix_mem[1] = 24'h000000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", pix_rd, 0);
    chk("rst_addr", pix_addr, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Spurious valid in IDLE.
    rb = rd_cnt;
    spur_valid = 1'b1;
    @(posedge clk); #1 spur_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_busy", busy, 0);
    chk("spur_dout", dout, 0);
    chk("spur_rd", rd_cnt - rb, 0);

    // Red then blue through the chain.
    pix_mem[0] = 24'h00FF00;
    pix_mem[1] = 24'h0000FF;
    run_frame("A", 1'b0, 1'b0, 48, 24'h00FF00, 24'h0000FF, DUR_FULL, 1'b0);

    // Pixel 1 arrives in cycle 300, well after the pixel-0 boundary (cycle 290).
    pix_mem[0] = 24'hFF0000;
    pix_mem[1] = 24'h123456;
    lat1 = 297;
    run_frame("U", 1'b0, 1'b0, 24, 24'hFF0000, 24'h0, DUR_UNDR, 1'b1);
    chk("U_dout_idle", dout, 0);
    lat1 = 1;

    // Next start clears underrun; starts while busy and in the done cycle ignored.
    pix_mem[0] = 24'hA5C35A;
    pix_mem[1] = 24'h5A3CA5;
    run_frame("B", 1'b1, 1'b1, 48, 24'hA5C35A, 24'h5A3CA5, DUR_FULL, 1'b0);

    // Reset during a high phase.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (dout !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("R_dout_high", dout, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("R_async_dout", dout, 0);
    chk("R_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("R_idle_busy", busy, 0);
    chk("R_idle_dout", dout, 0);

    pix_mem[0] = 24'hF0F00F;
    pix_mem[1] = 24'h0F0FF0;
    run_frame("D", 1'b0, 1'b0, 48, 24'hF0F00F, 24'h0F0FF0, DUR_FULL, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ws2812b_chain_ctrl.md
Name: ws2812b_chain_ctrl

Overview:
Master-side controller that drives a cascaded chain of ws2812b LEDs from a pixel source such as a frame buffer. On a start request it fetches NUM_LEDS 24-bit GRB words over a request/valid interface and serialises them MSB-first onto the one-wire dout line with WS2812B bit timing. It then holds the line low for the latch/reset period and signals completion. It is the block that feeds din of the first ws2812b in the chain.

Parameters:
NUM_LEDS, 8, number of pixels sent per frame (>=1)
T0H_CYCLES, 40, high time for a 0 bit (400 ns at 100 MHz)
T1H_CYCLES, 80, high time for a 1 bit (800 ns)
BIT_CYCLES, 125, total bit period (1.25 us); constraint T0H_CYCLES < T1H_CYCLES < BIT_CYCLES
LATCH_CYCLES, 6000, low time after the last bit (60 us; exceeds the 50 us receiver minimum)

Ports:
clk_100MHz  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle frame request
busy  output  1  high from the cycle after start is accepted until the cycle done pulses
done  output  1  one-cycle pulse at the end of the latch period
pix_rd  output  1  one-cycle pixel read request
pix_addr  output  clog2(NUM_LEDS) (min 1)  pixel index for pix_rd; held stable until pix_valid
pix_valid  input  1  pix_data valid; accepted only while a request is outstanding
pix_data  input  24  {G[7:0], R[7:0], B[7:0]}
underrun  output  1  sticky flag; set when a pixel is late, cleared on the next accepted start
dout  output  1  serial line to the first LED din

Behaviour:
- Reset (async): dout=0, busy=0, done=0, pix_rd=0, pix_addr=0, underrun=0, state=IDLE. All counters=0. Reset mid-frame aborts immediately; dout goes low with no completion of the current bit.
- States:
  - IDLE -> FETCH on start.
  - FETCH -> HIGH on pix_valid.
  - HIGH -> LOW when the high counter reaches T0H/T1H.
  - LOW -> HIGH for the next bit, or -> LATCH.
  - LATCH -> IDLE.
- IDLE: dout=0. start=1 is accepted. Next cycle: busy=1, pix_rd=1, pix_addr=0, underrun cleared.
- FETCH: waits indefinitely for pix_valid with dout=0.
  - On pix_valid, pix_data loads into the shift register; dout rises the next cycle.
  - In that same load cycle, if another pixel remains, pix_rd pulses with pix_addr+1 (prefetch).
- Bit encoding, MSB (bit 23) first:
  - dout=1 for exactly T1H_CYCLES (bit=1) or T0H_CYCLES (bit=0).
  - Then dout=0 for BIT_CYCLES minus the high time.
  - Every bit period is exactly BIT_CYCLES clocks.
- Pixel boundary: after the low phase of bit 0, the next pixel starts without a gap, provided its prefetched word has arrived.
  - The prefetched word is held in a 24-bit holding register and may arrive any time before the boundary.
  - On the boundary cycle the holding register moves to the shift register, and a new prefetch is issued if pixels remain.
- Underrun: prefetched data not present at the boundary.
  - Set underrun, abort the remaining pixels, enter LATCH with dout=0.
  - Any late pix_valid for that request is ignored.
- pix_valid arriving with no outstanding request is ignored. At most one request is outstanding at a time.
- After the last bit of pixel NUM_LEDS-1: LATCH holds dout=0 for LATCH_CYCLES clocks, then done=1 for one cycle with busy=0 in the same cycle, then IDLE.
- start while busy is ignored (not queued). start in the done cycle is ignored; it is accepted from the following cycle.
- Counters saturate to no wrap: bit counter 0..23, pixel counter 0..NUM_LEDS-1, timing counter 0..max(BIT_CYCLES, LATCH_CYCLES)-1.
- Frame duration with no stalls: first-fetch latency + NUM_LEDS*24*BIT_CYCLES + LATCH_CYCLES + 1 cycles.

Test Plan:
- NUM_LEDS=1, pix_data=0xFF0000 returned 1 cycle after pix_rd:
  - dout shows 8 pulses of 80 high/45 low, then 16 pulses of 40 high/85 low.
  - Then 6000 low cycles, then done.
  - A ws2812b model on dout ends with gled duty 255/256, rled=0, bled=0.
- NUM_LEDS=2, two chained ws2812b models, pixels 0x00FF00 then 0x0000FF:
  - The first model latches 0x00FF00 (red); the second latches 0x0000FF (blue).
  - No gap between the 48 bits.
- Source delays pix_valid for pixel 1 beyond the pixel-0 boundary:
  - underrun=1, dout low from the boundary, done after LATCH_CYCLES.
  - The late pix_valid is ignored.
  - The next start clears underrun.
- Reset asserted mid-bit during a high phase:
  - dout=0 and busy=0 asynchronously.
  - After release, a new start produces a clean full frame.
- start pulses while busy and in the done cycle:
  - No extra frame; pix_rd count equals NUM_LEDS per accepted start.
  - A spurious pix_valid in IDLE has no effect.
